minigol_sweep_ctrl: RTL and testbench
=====================================

# minigol_sweep_ctrl

Sequencer that runs Game-of-Life generations over a ROWS×COLS cell grid held in internal registers, one cell per clock, using the external per-cell compare unit (life + neighbour count in, flip flag out). It owns the grid state, computes each cell's neighbour count, collects flip flags for a full sweep, commits them atomically, and repeats for a host-requested number of generations. It sits between the host/load logic and the compare unit.

## Interface

Parameters:
- ROWS, 8: grid rows; must be ≥3.
- COLS, 8: grid columns; must be ≥3.
- GEN_W, 8: width of generation counters.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  GEN_W-independent 1  run request; sampled only in IDLE.
- gens  in  GEN_W  generations to run; sampled with start.
- load_en  in  1  row write strobe; honoured only in IDLE.
- load_row  in  $clog2(ROWS)  row index for load; values ≥ROWS ignored.
- load_data  in  COLS  row contents, bit c = column c.
- cmp_life  out  1  current cell state to compare unit.
- cmp_lifecount  out  4  live-neighbour count (0–8) to compare unit.
- cmp_update  in  1  combinational flip flag back from compare unit, same cycle.
- busy  out  1  high in SCAN and COMMIT.
- done  out  1  one-cycle pulse at end of run.
- stable  out  1  last committed generation had zero flips; cleared on accepted start.
- gen_cnt  out  GEN_W  generations committed in current/last run.
- changed_cnt  out  $clog2(ROWS*COLS+1)  flips in last committed generation.
- grid  out  ROWS*COLS  committed grid, bit r*COLS+c.

## Operation

- States: IDLE, SCAN, COMMIT, FINISH.
- Reset (async, rst_n low): state IDLE, grid all 0, flip mask 0, cell index 0, all outputs 0.
- IDLE: load_en writes grid row load_row. start with gens=0 → FINISH. start with gens>0 → SCAN, gen_cnt←0, stable←0, target latched. load_en and start on the same edge: load applied, run uses loaded grid.
- SCAN: cell index walks raster order (r=0..ROWS-1, c=0..COLS-1), one cell per cycle. Drives cmp_life = grid[idx], cmp_lifecount = count of 8 neighbours from the committed grid (not partially updated). Captures cmp_update into flip mask bit idx. After last cell → COMMIT.
- COMMIT (1 cycle): grid ← grid XOR mask; changed_cnt ← popcount(mask); gen_cnt+1; mask cleared. If popcount=0 → stable←1, FINISH (early stop). Else if gen_cnt+1 = target → FINISH. Else → SCAN, index 0.
- FINISH (1 cycle): done=1, → IDLE.
- Outside SCAN: cmp_life=0, cmp_lifecount=0.
- start/load_en outside IDLE ignored; no queuing.
- Edge handling per Configuration.

## Timing

- N = ROWS*COLS. Start accepted at edge t: SCAN cycles t+1…t+N, COMMIT at t+N+1; each generation costs N+1 cycles.
- Full run of G generations (no early stop): done high in cycle t+G·(N+1)+1; busy high cycles t+1…t+G·(N+1).
- gens=0: done high cycle t+1, busy never asserts, grid/gen_cnt unchanged except gen_cnt←0.
- grid, changed_cnt, gen_cnt, stable update only on COMMIT edge (stable also cleared at start); stable between commits.
- rst_n asserted mid-SCAN: immediate return to IDLE, grid cleared, no done pulse.

## Configuration

- TORUS_WRAP_EN defined: neighbours wrap modulo ROWS/COLS (toroidal grid).
- Undefined: out-of-grid neighbours count as dead; corner max count 3, edge max 5.

## Test plan

- Reset: rst_n low mid-SCAN of 8×8 run → next cycle busy=0, grid=0, done never pulses.
- Blinker: rows 3 = 0b0001_1100 only, gens=1 → grid has column 3, rows 2–4 live; changed_cnt=4; done at t+66; gens=2 returns original, gen_cnt=2.
- Block still life: 2×2 at (1,1), gens=5 → stops after one generation, stable=1, gen_cnt=1, changed_cnt=0, done at t+66.
- Glider near corner (rows 0–2 cols 5–7), gens=4: with TORUS_WRAP_EN shape reappears shifted by (1,1) wrapping to row 3 col 0 region; without it, result differs (edge cells die); compare against software model.
- load_en and start asserted while busy → grid, gen_cnt unchanged by them; start in same IDLE edge as load_en uses loaded row.
- gens=0 with start → done at t+1, busy stays 0, grid unchanged.

Source files
------------

// File: rtl/minigol_sweep_ctrl.sv
// Game-of-Life sweep sequencer: scans the grid one cell per clock through an external compare unit, commits flips per generation.
// Latency: N=ROWS*COLS scan cycles + 1 commit cycle per generation; done pulses one cycle after the final commit.
// No backpressure: start/load_en are only honoured in IDLE and dropped otherwise. Optional TORUS_WRAP_EN wraps neighbours toroidally.
module minigol_sweep_ctrl #(
    parameter int ROWS  = 8,
    parameter int COLS  = 8,
    parameter int GEN_W = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic [GEN_W-1:0]                 gens,
    input  logic                             load_en,
    input  logic [$clog2(ROWS)-1:0]          load_row,
    input  logic [COLS-1:0]                  load_data,
    output logic                             cmp_life,
    output logic [3:0]                       cmp_lifecount,
    input  logic                             cmp_update,
    output logic                             busy,
    output logic                             done,
    output logic                             stable,
    output logic [GEN_W-1:0]                 gen_cnt,
    output logic [$clog2(ROWS*COLS+1)-1:0]   changed_cnt,
    output logic [ROWS*COLS-1:0]             grid
);

    localparam int N     = ROWS * COLS;
    localparam int ROW_W = $clog2(ROWS);
    localparam int COL_W = $clog2(COLS);
    localparam int IDX_W = $clog2(N);
    localparam int CNT_W = $clog2(N + 1);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_COMMIT, S_FINISH} state_t;

    state_t             r_state;
    state_t             w_next;
    logic [ROW_W-1:0]   r_row;
    logic [COL_W-1:0]   r_col;
    logic [N-1:0]       r_grid;
    logic [N-1:0]       r_mask;
    logic [GEN_W-1:0]   r_target;
    logic [GEN_W-1:0]   r_gen_cnt;
    logic [CNT_W-1:0]   r_changed;
    logic               r_stable;

    logic [IDX_W-1:0]   w_idx;
    logic               w_last;
    logic [CNT_W-1:0]   w_pop;
    logic [GEN_W-1:0]   w_gen_inc;
    logic [3:0]         w_nbr;

    assign w_idx     = IDX_W'(32'(r_row) * COLS + 32'(r_col));
    assign w_last    = (r_row == ROW_W'(ROWS - 1)) && (r_col == COL_W'(COLS - 1));
    assign w_pop     = CNT_W'($countones(r_mask));
    assign w_gen_inc = r_gen_cnt + GEN_W'(1);

    // Neighbour count always reads the committed grid, never the pending flips.
    always_comb begin
        int nr;
        int nc;
        w_nbr = '0;
        nr    = 0;
        nc    = 0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                if (!(dr == 0 && dc == 0)) begin
                    nr = 32'(r_row) + dr;
                    nc = 32'(r_col) + dc;
`ifdef TORUS_WRAP_EN
                    if (nr < 0) nr = ROWS - 1;
                    else if (nr >= ROWS) nr = 0;
                    if (nc < 0) nc = COLS - 1;
                    else if (nc >= COLS) nc = 0;
                    w_nbr = w_nbr + 4'(r_grid[IDX_W'(nr * COLS + nc)]);
`else
                    if (nr >= 0 && nr < ROWS && nc >= 0 && nc < COLS)
                        w_nbr = w_nbr + 4'(r_grid[IDX_W'(nr * COLS + nc)]);
`endif
                end
            end
        end
    end

    always_comb begin
        w_next        = r_state;
        busy          = 1'b0;
        done          = 1'b0;
        cmp_life      = 1'b0;
        cmp_lifecount = 4'd0;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = (gens == '0) ? S_FINISH : S_SCAN;
            end
            S_SCAN: begin
                busy          = 1'b1;
                cmp_life      = r_grid[w_idx];
                cmp_lifecount = w_nbr;
                if (w_last) w_next = S_COMMIT;
            end
            S_COMMIT: begin
                busy = 1'b1;
                if (w_pop == '0 || w_gen_inc == r_target) w_next = S_FINISH;
                else                                      w_next = S_SCAN;
            end
            S_FINISH: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row     <= '0;
            r_col     <= '0;
            r_grid    <= '0;
            r_mask    <= '0;
            r_target  <= '0;
            r_gen_cnt <= '0;
            r_changed <= '0;
            r_stable  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // Row indices at or above ROWS match no row and are dropped.
                    for (int r = 0; r < ROWS; r++) begin
                        if (load_en && load_row == ROW_W'(r))
                            r_grid[r*COLS +: COLS] <= load_data;
                    end
                    if (start) begin
                        r_gen_cnt <= '0;
                        r_stable  <= 1'b0;
                        r_target  <= gens;
                        r_row     <= '0;
                        r_col     <= '0;
                        r_mask    <= '0;
                    end
                end
                S_SCAN: begin
                    r_mask[w_idx] <= cmp_update;
                    if (w_last) begin
                        r_row <= '0;
                        r_col <= '0;
                    end else if (r_col == COL_W'(COLS - 1)) begin
                        r_col <= '0;
                        r_row <= r_row + ROW_W'(1);
                    end else begin
                        r_col <= r_col + COL_W'(1);
                    end
                end
                S_COMMIT: begin
                    r_grid    <= r_grid ^ r_mask;
                    r_changed <= w_pop;
                    r_gen_cnt <= w_gen_inc;
                    r_mask    <= '0;
                    if (w_pop == '0) r_stable <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign stable      = r_stable;
    assign gen_cnt     = r_gen_cnt;
    assign changed_cnt = r_changed;
    assign grid        = r_grid;

endmodule

// File: tb/tb_minigol_sweep_ctrl.sv
// Bench for minigol_sweep_ctrl: directed patterns plus random grids against a software Life model.
module tb_minigol_sweep_ctrl;

    localparam int ROWS = 8;
    localparam int COLS = 8;
    localparam int N    = ROWS * COLS;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  gens;
    logic        load_en;
    logic [2:0]  load_row;
    logic [7:0]  load_data;
    logic        cmp_life;
    logic [3:0]  cmp_lifecount;
    logic        cmp_update;
    logic        busy;
    logic        done;
    logic        stable;
    logic [7:0]  gen_cnt;
    logic [6:0]  changed_cnt;
    logic [63:0] grid;

    int          total = 0;
    int          bad   = 0;
    logic [63:0] m_grid;

    minigol_sweep_ctrl #(.ROWS(ROWS), .COLS(COLS), .GEN_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .gens(gens),
        .load_en(load_en), .load_row(load_row), .load_data(load_data),
        .cmp_life(cmp_life), .cmp_lifecount(cmp_lifecount), .cmp_update(cmp_update),
        .busy(busy), .done(done), .stable(stable), .gen_cnt(gen_cnt),
        .changed_cnt(changed_cnt), .grid(grid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External compare unit: standard B3/S23 rule expressed as a flip flag.
    assign cmp_update = cmp_life ? !(cmp_lifecount == 4'd2 || cmp_lifecount == 4'd3)
                                 : (cmp_lifecount == 4'd3);

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int nbr(input logic [63:0] g, input int r, input int c);
        int n;
        int rr;
        int cc;
        n = 0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                if (dr != 0 || dc != 0) begin
                    rr = r + dr;
                    cc = c + dc;
`ifdef TORUS_WRAP_EN
                    rr = (rr + ROWS) % ROWS;
                    cc = (cc + COLS) % COLS;
                    n += int'(g[rr*COLS + cc]);
`else
                    if (rr >= 0 && rr < ROWS && cc >= 0 && cc < COLS)
                        n += int'(g[rr*COLS + cc]);
`endif
                end
            end
        end
        return n;
    endfunction

    function automatic logic [63:0] step(input logic [63:0] g);
        logic [63:0] nx;
        int n;
        nx = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                n = nbr(g, r, c);
                nx[r*COLS + c] = g[r*COLS + c] ? (n == 2 || n == 3) : (n == 3);
            end
        end
        return nx;
    endfunction

    task automatic load_row_t(input int r, input logic [7:0] d);
        @(negedge clk);
        load_en   = 1'b1;
        load_row  = 3'(r);
        load_data = d;
        @(negedge clk);
        load_en   = 1'b0;
        m_grid[r*COLS +: COLS] = d;
    endtask

    task automatic clear_grid();
        for (int r = 0; r < ROWS; r++) load_row_t(r, 8'h00);
    endtask

    task automatic run(input logic [7:0] g, input bit disturb, input bit with_load,
                       input int lrow, input logic [7:0] ldata);
        logic [63:0] cur;
        logic [63:0] nxt;
        logic [63:0] g0;
        int flips;
        int ng;
        int exp_done;
        int cyc;
        int busyc;
        bit exp_stable;
        bit seen;
        @(negedge clk);
        if (with_load) begin
            load_en   = 1'b1;
            load_row  = 3'(lrow);
            load_data = ldata;
            m_grid[lrow*COLS +: COLS] = ldata;
        end
        start = 1'b1;
        gens  = g;
        @(negedge clk);
        start   = 1'b0;
        load_en = 1'b0;

        cur = m_grid;
        g0  = m_grid;
        ng = 0;
        flips = 0;
        exp_stable = 1'b0;
        for (int i = 0; i < int'(g); i++) begin
            nxt   = step(cur);
            flips = $countones(cur ^ nxt);
            cur   = nxt;
            ng++;
            if (flips == 0) begin
                exp_stable = 1'b1;
                break;
            end
        end
        exp_done = ng * (N + 1) + 1;

        cyc = 1;
        busyc = 0;
        seen = 1'b0;
        while (cyc <= exp_done + 20) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) busyc++;
            if (g != 0 && cyc <= N) begin
                check("cmp_life", 64'(cmp_life), 64'(g0[cyc-1]));
                check("cmp_lifecount", 64'(cmp_lifecount), 64'(nbr(g0, (cyc-1) / COLS, (cyc-1) % COLS)));
            end
            if (disturb && cyc == 5) begin
                load_en   = 1'b1;
                load_row  = 3'($urandom_range(0, 7));
                load_data = 8'($urandom);
                start     = 1'b1;
                gens      = 8'd1;
            end
            if (disturb && cyc == 6) begin
                load_en = 1'b0;
                start   = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        check("done_seen", 64'(seen), 64'(1));
        check("done_cycle", 64'(cyc), 64'(exp_done));
        check("busy_cycles", 64'(busyc), 64'(ng * (N + 1)));
        check("grid", grid, cur);
        check("gen_cnt", 64'(gen_cnt), 64'(ng));
        check("idle_lifecount", 64'(cmp_lifecount), 64'(0));
        if (ng > 0) begin
            check("changed_cnt", 64'(changed_cnt), 64'(flips));
            check("stable", 64'(stable), 64'(exp_stable));
        end
        m_grid = cur;
        @(negedge clk);
        check("done_one_cycle", 64'(done), 64'(0));
    endtask

    initial begin
        int pulses;
        rst_n = 1'b0; start = 1'b0; gens = '0; load_en = 1'b0; load_row = '0; load_data = '0;
        m_grid = '0;
        #1;
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_grid", grid, 64'(0));
        check("rst_gen_cnt", 64'(gen_cnt), 64'(0));
        check("rst_changed", 64'(changed_cnt), 64'(0));
        check("rst_stable", 64'(stable), 64'(0));
        check("rst_cmp", 64'({cmp_life, cmp_lifecount}), 64'(0));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Blinker, one and two generations
        load_row_t(3, 8'b0001_1100);
        check("load_grid", grid, m_grid);
        run(8'd1, 1'b0, 1'b0, 0, 8'h00);
        check("blinker_vertical", grid, (64'h1 << (2*8+3)) | (64'h1 << (3*8+3)) | (64'h1 << (4*8+3)));
        check("blinker_changed", 64'(changed_cnt), 64'(4));
        clear_grid();
        load_row_t(3, 8'b0001_1100);
        run(8'd2, 1'b0, 1'b0, 0, 8'h00);
        check("blinker_back", grid, 64'h0000_0000_1C00_0000);

        // Block still life stops early
        clear_grid();
        load_row_t(1, 8'b0000_0110);
        load_row_t(2, 8'b0000_0110);
        run(8'd5, 1'b0, 1'b0, 0, 8'h00);
        check("block_stable", 64'(stable), 64'(1));
        check("block_gen_cnt", 64'(gen_cnt), 64'(1));

        // Glider against the corner
        clear_grid();
        load_row_t(0, 8'b0100_0000);
        load_row_t(1, 8'b1000_0000);
        load_row_t(2, 8'b1110_0000);
        run(8'd4, 1'b0, 1'b0, 0, 8'h00);

        // gens=0 leaves grid alone
        run(8'd0, 1'b0, 1'b0, 0, 8'h00);

        // Load on the same edge as start, and disturbances while busy
        clear_grid();
        run(8'd2, 1'b1, 1'b1, 4, 8'b0011_1000);
        for (int k = 0; k < 4; k++) begin
            for (int r = 0; r < ROWS; r++) load_row_t(r, 8'($urandom));
            run(8'($urandom_range(1, 4)), bit'(k[0]), 1'b0, 0, 8'h00);
        end

        // Asynchronous reset in the middle of a sweep
        for (int r = 0; r < ROWS; r++) load_row_t(r, 8'($urandom) | 8'h01);
        @(negedge clk);
        start = 1'b1;
        gens  = 8'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_grid", grid, 64'(0));
        check("midrst_gen_cnt", 64'(gen_cnt), 64'(0));
        pulses = 0;
        repeat (5) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("midrst_no_done", 64'(pulses), 64'(0));
        rst_n  = 1'b1;
        m_grid = '0;
        load_row_t(5, 8'b0000_1110);
        run(8'd1, 1'b0, 1'b0, 0, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
